univ_shift_reg: RTL and testbench
=================================

Name: univ_shift_reg

Overview:
- Parametrised universal shift register; successor to the 4-bit load/shift-up register.
- Adds width generalisation, bidirectional shift, rotate, arithmetic shift-down and an auto-transfer engine that shifts a programmed bit count and then signals completion.
- Serves as the serial/parallel converter for the serial-link and bit-serial arithmetic datapaths.

Parameters:
W, 8, register width in bits (legal range 2 to 64)
CW, $clog2(W+1), width of the transfer-length field (derived; do not override)

Ports:
clk  input  1  rising-edge clock
rstn  input  1  asynchronous active-low reset
mode  input  3  manual operation select; ignored while busy=1
din  input  W  parallel load data
si_up  input  1  serial input; enters bit 0 on a shift-up
si_dn  input  1  serial input; enters bit W-1 on a shift-down
start  input  1  begin an auto-transfer (sampled only in IDLE)
dir  input  1  auto-transfer direction: 0=up (toward MSB), 1=down; sampled with start
len  input  CW  auto-transfer bit count, 0..W; sampled with start
abort  input  1  terminate an auto-transfer immediately
q  output  W  register contents
so_up  output  1  q[W-1]
so_dn  output  1  q[0]
busy  output  1  auto-transfer in progress
done  output  1  one-cycle pulse when an auto-transfer completes

Behaviour:
- Reset: rstn=0 clears q=0, busy=0 and done=0 asynchronously, and places the FSM in IDLE with the counter at 0. A reset mid-transfer discards the transfer; no done pulse.
- Manual modes, applied on the clock edge in IDLE when start=0:
  - 000 hold
  - 001 load: q<=din
  - 010 shift up: q<={q[W-2:0],si_up}
  - 011 shift down: q<={si_dn,q[W-1:1]}
  - 100 rotate up: q<={q[W-2:0],q[W-1]}
  - 101 rotate down: q<={q[0],q[W-1:1]}
  - 110 arithmetic shift down: q<={q[W-1],q[W-1:1]}
  - 111 hold (reserved)
- FSM states are IDLE and RUN.
- IDLE with start=1:
  - start takes priority over mode; q holds that cycle; dir and len are captured.
  - If len>0: go to RUN, cnt<=len, busy=1 from the next cycle.
  - If len=0: stay in IDLE, no shift, done=1 on the next cycle.
  - If len>W: treated as W.
- RUN: each cycle, shift q once in the captured direction using si_up/si_dn (same as modes 010/011), and decrement cnt. The cycle in which cnt==1 performs the last shift, after which the FSM returns to IDLE, busy=0 and done=1 for exactly one cycle. Total: len shifts over len cycles; busy is high for len cycles.
- abort=1 in RUN: no shift that edge; return to IDLE; busy=0; no done. abort in IDLE has no effect.
- start asserted while busy=1 is ignored and not queued. mode, din and new len/dir are ignored in RUN.
- done is registered and never coincides with busy=1. A new start is accepted in the same cycle done is high.
- q, so_up and so_dn are combinational from the register. There is no combinational path from inputs to any output.

Decomposition:
- Shared package usr_pkg holds:
  - mode encodings as localparams MODE_HOLD, MODE_LOAD, MODE_SHU, MODE_SHD, MODE_ROTU, MODE_ROTD, MODE_ASHD
  - FSM state encodings ST_IDLE and ST_RUN
  - direction constants DIR_UP and DIR_DN
- One sub-module, usr_xfer_ctrl, is natural. It contains the FSM, the length counter and the busy/done generation, and outputs a per-cycle shift enable and direction.
- The datapath mux and register stay in the top level.

Test Plan:
- Reset then W=8 load din=8'hA5 -> q=8'hA5, so_up=1, so_dn=1. Assert rstn=0 mid-cycle -> q=0 immediately.
- q=8'hA5, shift up 4 cycles with si_up=1 -> q=8'h5F. Then arithmetic shift down 2 cycles -> q=8'h17. From q=8'h81, one arithmetic shift down -> q=8'hC0.
- q=8'h81, rotate up once -> 8'h03. Rotate down once from 8'h81 -> 8'hC0. Hold 3 cycles -> unchanged.
- q=0, start with dir=up, len=8, si_up driven with 1,0,1,1,0,0,1,0 (first bit first) -> busy high for 8 cycles, q=8'hB2, done one cycle after busy falls, no further shifts.
- Start with len=3 and dir=down, with start pulsed again and mode=load during RUN -> exactly 3 shifts; load and second start ignored; a single done pulse. Separately, start with len=0 -> done next cycle, q unchanged, busy never high.
- Start with len=6, abort asserted on the 3rd RUN cycle -> exactly 2 shifts applied, busy=0 next cycle, done never asserted. Separately, rstn pulsed low during RUN -> q=0, busy=0, no done.

Source files
------------

// File: rtl/usr_pkg.sv
`default_nettype none
// ============================================================================
// Module : usr_pkg
// Desc   : Shared encodings for the universal shift register and its
//          auto-transfer controller.
// Rev    : 1.0  initial release
// ============================================================================
package usr_pkg;

    localparam logic [2:0] MODE_HOLD = 3'b000;
    localparam logic [2:0] MODE_LOAD = 3'b001;
    localparam logic [2:0] MODE_SHU  = 3'b010;
    localparam logic [2:0] MODE_SHD  = 3'b011;
    localparam logic [2:0] MODE_ROTU = 3'b100;
    localparam logic [2:0] MODE_ROTD = 3'b101;
    localparam logic [2:0] MODE_ASHD = 3'b110;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    localparam logic DIR_UP = 1'b0;
    localparam logic DIR_DN = 1'b1;

endpackage : usr_pkg
`default_nettype wire

// File: rtl/usr_xfer_ctrl.sv
`default_nettype none
// ============================================================================
// Module : usr_xfer_ctrl
// Desc   : Auto-transfer FSM: counts a programmed number of shifts, issues a
//          per-cycle shift enable/direction and a one-cycle done pulse.
// Rev    : 1.0  initial release
// ============================================================================
module usr_xfer_ctrl
    import usr_pkg::*;
#(
    parameter int W  = 8,
    parameter int CW = $clog2(W + 1)
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          start,
    input  logic          dir,
    input  logic [CW-1:0] len,
    input  logic          abort,
    output logic          busy,
    output logic          done,
    output logic          shift_en,
    output logic          shift_dir
);

    localparam logic [CW-1:0] c_max_len = CW'(W);

    logic [0:0]    r_state;
    logic [CW-1:0] r_cnt;
    logic          r_dir;
    logic          r_done;
    logic [CW-1:0] w_len_sat;

    assign w_len_sat = (len > c_max_len) ? c_max_len : len;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_dir   <= DIR_UP;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_dir <= dir;
                        if (w_len_sat == '0) begin
                            r_done <= 1'b1;
                        end else begin
                            r_cnt   <= w_len_sat;
                            r_state <= ST_RUN;
                        end
                    end
                end
                ST_RUN: begin
                    // Abort wins over the final shift: no done on abort.
                    if (abort) begin
                        r_cnt   <= '0;
                        r_state <= ST_IDLE;
                    end else if (r_cnt == CW'(1)) begin
                        r_cnt   <= '0;
                        r_state <= ST_IDLE;
                        r_done  <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - CW'(1);
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign busy      = (r_state == ST_RUN);
    assign done      = r_done;
    assign shift_en  = (r_state == ST_RUN) && !abort;
    assign shift_dir = r_dir;

endmodule : usr_xfer_ctrl
`default_nettype wire

// File: rtl/univ_shift_reg.sv
`default_nettype none
// ============================================================================
// Module : univ_shift_reg
// Desc   : Parametrised universal shift register with load, shift, rotate,
//          arithmetic shift-down and a counted auto-transfer engine.
// Rev    : 1.0  initial release
// ============================================================================
module univ_shift_reg
    import usr_pkg::*;
#(
    parameter int W  = 8,
    parameter int CW = $clog2(W + 1)
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic [2:0]    mode,
    input  logic [W-1:0]  din,
    input  logic          si_up,
    input  logic          si_dn,
    input  logic          start,
    input  logic          dir,
    input  logic [CW-1:0] len,
    input  logic          abort,
    output logic [W-1:0]  q,
    output logic          so_up,
    output logic          so_dn,
    output logic          busy,
    output logic          done
);

    logic [W-1:0] r_q;
    logic [W-1:0] w_q_nxt;
    logic         w_busy;
    logic         w_shift_en;
    logic         w_shift_dir;

    usr_xfer_ctrl #(
        .W  (W),
        .CW (CW)
    ) u_xfer_ctrl (
        .clk       (clk),
        .rstn      (rstn),
        .start     (start),
        .dir       (dir),
        .len       (len),
        .abort     (abort),
        .busy      (w_busy),
        .done      (done),
        .shift_en  (w_shift_en),
        .shift_dir (w_shift_dir)
    );

    // Manual modes only apply in IDLE without start; start holds q that cycle.
    always_comb begin
        w_q_nxt = r_q;
        if (w_shift_en) begin
            if (w_shift_dir == DIR_UP) w_q_nxt = {r_q[W-2:0], si_up};
            else                       w_q_nxt = {si_dn, r_q[W-1:1]};
        end else if (!w_busy && !start) begin
            case (mode)
                MODE_LOAD: w_q_nxt = din;
                MODE_SHU:  w_q_nxt = {r_q[W-2:0], si_up};
                MODE_SHD:  w_q_nxt = {si_dn, r_q[W-1:1]};
                MODE_ROTU: w_q_nxt = {r_q[W-2:0], r_q[W-1]};
                MODE_ROTD: w_q_nxt = {r_q[0], r_q[W-1:1]};
                MODE_ASHD: w_q_nxt = {r_q[W-1], r_q[W-1:1]};
                default:   w_q_nxt = r_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) r_q <= '0;
        else       r_q <= w_q_nxt;
    end

    assign q     = r_q;
    assign so_up = r_q[W-1];
    assign so_dn = r_q[0];
    assign busy  = w_busy;

endmodule : univ_shift_reg
`default_nettype wire

// File: tb/tb_univ_shift_reg.sv
`default_nettype none
// ============================================================================
// Module : tb_univ_shift_reg
// Desc   : Directed self-checking bench for univ_shift_reg (W=8).
// Rev    : 1.0  initial release
// ============================================================================
module tb_univ_shift_reg;

    localparam int W  = 8;
    localparam int CW = $clog2(W + 1);

    logic          clk = 1'b0;
    logic          rstn;
    logic [2:0]    mode;
    logic [W-1:0]  din;
    logic          si_up, si_dn, start, dir, abort;
    logic [CW-1:0] len;
    logic [W-1:0]  q;
    logic          so_up, so_dn, busy, done;

    int total = 0;
    int bad   = 0;

    univ_shift_reg #(.W(W)) dut (
        .clk   (clk),   .rstn  (rstn),  .mode  (mode),  .din   (din),
        .si_up (si_up), .si_dn (si_dn), .start (start), .dir   (dir),
        .len   (len),   .abort (abort), .q     (q),     .so_up (so_up),
        .so_dn (so_dn), .busy  (busy),  .done  (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        total++;
        if (obs !== exp_v) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [W-1:0] v);
        mode = 3'b001; din = v; tick(); mode = 3'b000;
    endtask

    initial begin
        logic [7:0] bits;
        int         nbusy;

        rstn = 1'b0; mode = 3'b000; din = '0; si_up = 1'b0; si_dn = 1'b0;
        start = 1'b0; dir = 1'b0; len = '0; abort = 1'b0;
        #12;
        chk("rst_q", 64'(q), 64'h0);
        chk("rst_busy", 64'(busy), 64'h0);
        chk("rst_done", 64'(done), 64'h0);
        rstn = 1'b1;
        tick();

        load(8'hA5);
        chk("load_q", 64'(q), 64'hA5);
        chk("load_so_up", 64'(so_up), 64'h1);
        chk("load_so_dn", 64'(so_dn), 64'h1);
        #2 rstn = 1'b0;
        #1 chk("async_rst_q", 64'(q), 64'h0);
        rstn = 1'b1;
        tick();

        load(8'hA5);
        si_up = 1'b1; mode = 3'b010;
        repeat (4) tick();
        chk("shu4", 64'(q), 64'h5F);
        mode = 3'b110;
        repeat (2) tick();
        chk("ashd2", 64'(q), 64'h17);
        load(8'h81); mode = 3'b110; tick();
        chk("ashd_neg", 64'(q), 64'hC0);
        load(8'h81); mode = 3'b100; tick();
        chk("rotu", 64'(q), 64'h03);
        load(8'h81); mode = 3'b101; tick();
        chk("rotd", 64'(q), 64'hC0);
        mode = 3'b000; repeat (3) tick();
        chk("hold3", 64'(q), 64'hC0);
        si_dn = 1'b0; mode = 3'b011; tick();
        chk("shd", 64'(q), 64'h60);
        mode = 3'b111; tick();
        chk("reserved_hold", 64'(q), 64'h60);
        mode = 3'b000;

        // Auto-transfer up, 8 bits, first bit ends at MSB
        load(8'h00);
        start = 1'b1; dir = 1'b0; len = CW'(8); tick(); start = 1'b0;
        chk("xfer_start_q", 64'(q), 64'h00);
        bits = 8'b1011_0010;
        for (int i = 0; i < 8; i++) begin
            chk("xfer_busy", 64'(busy), 64'h1);
            si_up = bits[7-i];
            tick();
        end
        chk("xfer_q", 64'(q), 64'hB2);
        chk("xfer_busy_end", 64'(busy), 64'h0);
        chk("xfer_done", 64'(done), 64'h1);
        tick();
        chk("xfer_done_pulse", 64'(done), 64'h0);
        chk("xfer_q_after", 64'(q), 64'hB2);

        // Down transfer of 3 with stray start and load during RUN
        si_dn = 1'b1;
        start = 1'b1; dir = 1'b1; len = CW'(3); tick();
        start = 1'b1; mode = 3'b001; din = 8'hFF; dir = 1'b0; len = CW'(7);
        chk("dn_done_early", 64'(done), 64'h0);
        tick(); start = 1'b0;
        chk("dn_done_mid", 64'(done), 64'h0);
        tick();
        chk("dn_busy_last", 64'(busy), 64'h1);
        tick(); mode = 3'b000;
        chk("dn_q", 64'(q), 64'hF6);
        chk("dn_done", 64'(done), 64'h1);
        chk("dn_busy_end", 64'(busy), 64'h0);
        tick();
        chk("dn_single_done", 64'(done), 64'h0);
        chk("dn_q_hold", 64'(q), 64'hF6);

        // Zero-length transfer
        start = 1'b1; dir = 1'b0; len = CW'(0); tick(); start = 1'b0;
        chk("len0_done", 64'(done), 64'h1);
        chk("len0_busy", 64'(busy), 64'h0);
        chk("len0_q", 64'(q), 64'hF6);
        tick();
        chk("len0_done_clr", 64'(done), 64'h0);

        // Over-length saturates to W
        load(8'h00);
        si_up = 1'b1;
        start = 1'b1; dir = 1'b0; len = CW'(12); tick(); start = 1'b0;
        nbusy = 0;
        for (int i = 0; i < 20 && busy; i++) begin
            nbusy++;
            tick();
        end
        chk("sat_busy_cycles", 64'(nbusy), 64'd8);
        chk("sat_q", 64'(q), 64'hFF);
        chk("sat_done", 64'(done), 64'h1);

        // Abort on 3rd RUN cycle
        si_up = 1'b0;
        start = 1'b1; dir = 1'b0; len = CW'(6); tick(); start = 1'b0;
        tick(); tick();
        abort = 1'b1; tick(); abort = 1'b0;
        chk("abort_q", 64'(q), 64'hFC);
        chk("abort_busy", 64'(busy), 64'h0);
        chk("abort_done", 64'(done), 64'h0);
        tick();
        chk("abort_done_next", 64'(done), 64'h0);
        chk("abort_q_hold", 64'(q), 64'hFC);

        // Reset mid-transfer
        start = 1'b1; dir = 1'b0; len = CW'(5); tick(); start = 1'b0;
        tick();
        #2 rstn = 1'b0;
        #1 chk("rstrun_q", 64'(q), 64'h0);
        chk("rstrun_busy", 64'(busy), 64'h0);
        tick();
        rstn = 1'b1;
        tick();
        chk("rstrun_done", 64'(done), 64'h0);
        chk("rstrun_busy2", 64'(busy), 64'h0);
        chk("rstrun_q2", 64'(q), 64'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_univ_shift_reg
`default_nettype wire
